// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite slave slot bus bundle
interface ahb_slave_mem_if;
    logic        Hsel;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;

    modport master (
        output Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hreadyin,
        input  Hreadyout, Hresp, Hrdata
    );

    modport slave (
        input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hreadyin,
        output Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite slave with byte-lane RAM, wait states and ERROR response
module ahb_slave_mem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic           Hclk,
    input  logic           Hresetn,
    ahb_slave_mem_if.slave bus
);
    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              illegal;
    logic              enter_data;
    logic              do_write;
    logic [3:0]        wr_be;
    logic [ADDR_W-3:0] rd_idx;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign unused_bits = ^{bus.Haddr[31:ADDR_W], bus.Htrans[0]};

    assign accept  = bus.Hsel & bus.Hreadyin & bus.Htrans[1];
    assign illegal = (bus.Hsize > 3'd2)
                   | ((bus.Hsize == 3'd1) & bus.Haddr[0])
                   | ((bus.Hsize == 3'd2) & (|bus.Haddr[1:0]));

    // Only a write sitting in its completion cycle touches the RAM
    assign do_write = (state_q == ST_DATA) & write_q;

    // Read address: the latched one after wait states, otherwise the live address phase
    assign rd_idx = (state_q == ST_WAIT) ? addr_q[ADDR_W-1:2] : bus.Haddr[ADDR_W-1:2];

    // Byte lanes of the transfer in its data phase
    always_comb begin
        wr_be = 4'b0000;
        case (size_q)
            3'd0:    wr_be[addr_q[1:0]] = 1'b1;
            3'd1:    wr_be = addr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // Read word, with bytes of a same-cycle completing write forwarded in
    always_comb begin
        rd_word = mem[rd_idx];
        if (do_write && (addr_q[ADDR_W-1:2] == rd_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = bus.Hwdata[8*i +: 8];
            end
        end
    end

    // Next-state, address/control latch and wait counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        enter_data = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_DATA;
                    enter_data = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    addr_d  = bus.Haddr[ADDR_W-1:0];
                    write_d = bus.Hwrite;
                    size_d  = bus.Hsize;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d    = ST_DATA;
                        enter_data = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        rdata_d = enter_data ? rd_word : rdata_q;
    end

    // Control state registers
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge Hclk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= bus.Hwdata[8*i +: 8];
            end
        end
    end

    assign bus.Hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign bus.Hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign bus.Hrdata    = rdata_q;
endmodule
